// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S types, channel constants and default sizes
package i2s_pkg;

  typedef enum logic [1:0] {IDLE, START, RUN, DRAIN} i2s_state_e;

  localparam logic I2S_LEFT  = 1'b0;
  localparam logic I2S_RIGHT = 1'b1;

  localparam int I2S_CLK_DIV  = 4;
  localparam int I2S_SAMPLE_W = 16;
  localparam int I2S_SLOT_W   = 16;

endpackage

// File: rtl/i2s_bclk_gen.sv
// rtl/i2s_bclk_gen.sv - bit clock divider with single-cycle rise/fall strobes
module i2s_bclk_gen
  import i2s_pkg::*;
#(
  parameter int CLK_DIV = I2S_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bclk,
  output logic rise,
  output logic fall
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             wrap;

  // Strobes mark the clk edge on which bclk is about to change.
  assign wrap = !clear && (div_cnt == DIV_LAST);
  assign rise = wrap && !bclk;
  assign fall = wrap && bclk;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      bclk    <= !bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_serial_out.sv
// rtl/i2s_serial_out.sv - Philips I2S transmitter: sample requests, framing FSM, serializer
module i2s_serial_out
  import i2s_pkg::*;
#(
  parameter int CLK_DIV  = I2S_CLK_DIV,
  parameter int SAMPLE_W = I2S_SAMPLE_W,
  parameter int SLOT_W   = I2S_SLOT_W,
  parameter bit MONO     = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] sample_data,
  output logic                sample_req,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata,
  output logic                busy
);

  localparam int BIT_W   = $clog2(SLOT_W);
  localparam int START_W = $clog2(2 * CLK_DIV);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(SLOT_W - 1);
  localparam logic [BIT_W-1:0]   BIT_PENULT = BIT_W'(SLOT_W - 2);
  localparam logic [START_W-1:0] START_LAST = START_W'(2 * CLK_DIV - 1);

  i2s_state_e          state;
  logic [BIT_W-1:0]    bit_cnt;
  logic [START_W-1:0]  start_cnt;
  logic [SLOT_W-1:0]   shreg;
  logic [SLOT_W-1:0]   load_word;
  logic [SAMPLE_W-1:0] held;
  logic [SAMPLE_W-1:0] load_sample;
  logic                div_clear;
  logic                bclk_fall;
  logic                bclk_rise_unused;

  assign div_clear = (state == IDLE) || (state == START);

  i2s_bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (div_clear),
    .bclk  (bclk),
    .rise  (bclk_rise_unused),
    .fall  (bclk_fall)
  );

  // Mono replays the left sample into the right slot; padding sits below the sample.
  always_comb begin
    load_sample = (MONO && (lrclk == I2S_RIGHT)) ? held : sample_data;
    load_word = '0;
    load_word[SLOT_W-1 -: SAMPLE_W] = load_sample;
  end

  // shreg holds the bits still to follow the one currently on sdata.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      start_cnt  <= '0;
      shreg      <= '0;
      held       <= '0;
      sample_req <= 1'b0;
      lrclk      <= 1'b0;
      sdata      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sample_req <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            sample_req <= 1'b1;
            busy       <= 1'b1;
            start_cnt  <= '0;
            state      <= START;
          end
        end
        START: begin
          if (start_cnt == START_LAST) begin
            shreg   <= load_word << 1;
            sdata   <= load_word[SLOT_W-1];
            held    <= sample_data;
            bit_cnt <= '0;
            state   <= RUN;
          end else begin
            start_cnt <= start_cnt + 1'b1;
          end
        end
        RUN, DRAIN: begin
          if ((state == RUN) && !enable) state <= DRAIN;
          if (bclk_fall) begin
            if (bit_cnt == BIT_LAST) begin
              if ((state == DRAIN) && (lrclk == I2S_LEFT)) begin
                state   <= IDLE;
                busy    <= 1'b0;
                sdata   <= 1'b0;
                shreg   <= '0;
                bit_cnt <= '0;
              end else begin
                shreg   <= load_word << 1;
                sdata   <= load_word[SLOT_W-1];
                bit_cnt <= '0;
                if (lrclk == I2S_LEFT) held <= sample_data;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= shreg << 1;
              sdata   <= shreg[SLOT_W-1];
              // lrclk leads the next slot's MSB by one bclk.
              if (bit_cnt == BIT_PENULT) begin
                lrclk      <= !lrclk;
                sample_req <= (state == RUN) && enable && (!MONO || (lrclk == I2S_RIGHT));
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_serial_out.sv
// tb/tb_i2s_serial_out.sv - scoreboard bench for i2s_serial_out over three configurations
module tb_i2s_serial_out;

  logic clk = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  logic en     [3];
  logic rstn   [3];
  logic req_w  [3];
  logic bclk_w [3];
  logic lr_w   [3];
  logic sd_w   [3];
  logic busy_w [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input longint act, input longint expv);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Instance 0: stereo CLK_DIV=4 SLOT_W=16; 1: mono SLOT_W=24; 2: stereo CLK_DIV=2.
  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int CD = (g == 2) ? 2 : 4;
    localparam int SW = (g == 1) ? 24 : 16;
    localparam bit MN = (g == 1);

    logic [15:0] smp;
    logic [15:0] last_smp;
    logic [15:0] exp_q [$];
    int          t_req;
    bit          pending;

    i2s_serial_out #(.CLK_DIV(CD), .SAMPLE_W(16), .SLOT_W(SW), .MONO(MN)) dut (
      .clk         (clk),
      .rst_n       (rstn[g]),
      .enable      (en[g]),
      .sample_data (smp),
      .sample_req  (req_w[g]),
      .bclk        (bclk_w[g]),
      .lrclk       (lr_w[g]),
      .sdata       (sd_w[g]),
      .busy        (busy_w[g])
    );

    // FIFO model: presents a new sample on each request and records what each slot must carry.
    initial begin : driver
      int t_prev;
      int nreq;
      bit dropped;
      bit prev_req;
      smp = '0; last_smp = '0; t_req = 0; pending = 0;
      t_prev = -1; nreq = 0; dropped = 0; prev_req = 0;
      forever begin
        @(negedge clk);
        if (!rstn[g]) begin
          check({req_w[g], bclk_w[g], lr_w[g], sd_w[g], busy_w[g]} == 5'b0,
                $sformatf("i%0d_reset_outputs", g),
                {req_w[g], bclk_w[g], lr_w[g], sd_w[g], busy_w[g]}, 0);
          t_prev = -1; pending = 0; dropped = 0; prev_req = 0;
        end else begin
          if (!busy_w[g]) begin
            dropped = 0;
            t_prev  = -1;
          end
          if (busy_w[g] && !en[g]) dropped = 1;
          if (req_w[g]) begin
            check(!prev_req && !dropped, $sformatf("i%0d_req_legal", g), {prev_req, dropped}, 0);
            if (t_prev >= 0)
              check(cyc - t_prev == (MN ? 4 : 2) * CD * SW, $sformatf("i%0d_req_spacing", g),
                    cyc - t_prev, (MN ? 4 : 2) * CD * SW);
            t_prev  = cyc;
            t_req   = cyc;
            pending = 1;
            case (nreq)
              0:       smp = 16'hA5C3;
              1:       smp = 16'h3C5A;
              2:       smp = 16'h8001;
              3:       smp = 16'hFFFF;
              default: smp = 16'($urandom);
            endcase
            nreq++;
            exp_q.push_back(smp);
            if (MN) exp_q.push_back(smp);
            last_smp = smp;
          end
          prev_req = req_w[g];
        end
      end
    end

    // I2S receiver: bits sampled on bclk rising edges, slot n%SW, lrclk one bit early.
    initial begin : monitor
      int          nbits;
      int          bi;
      int          t_rise;
      int          t_lrf;
      logic        pb, plr, pbusy;
      logic [31:0] word;
      logic [15:0] e;
      nbits = 0; t_rise = -1; t_lrf = -1; pb = 0; plr = 0; pbusy = 0; word = '0;
      forever begin
        @(negedge clk);
        if (!rstn[g]) begin
          exp_q.delete();
          nbits = 0; t_rise = -1; t_lrf = -1; pb = 0; plr = 0; pbusy = 0;
        end else begin
          if (bclk_w[g] && !pb) begin
            if (t_rise >= 0)
              check(cyc - t_rise == 2 * CD, $sformatf("i%0d_bclk_period", g), cyc - t_rise, 2 * CD);
            t_rise = cyc;
            bi = nbits % SW;
            check(lr_w[g] == 1'(((nbits + 1) / SW) % 2), $sformatf("i%0d_lrclk_bit%0d", g, nbits),
                  lr_w[g], ((nbits + 1) / SW) % 2);
            word = (bi == 0) ? 32'(sd_w[g]) : {word[30:0], sd_w[g]};
            if (bi == 0 && pending) begin
              check(cyc - t_req == 3 * CD, $sformatf("i%0d_load_delay", g), cyc - t_req, 3 * CD);
              pending = 0;
            end
            if (bi == SW - 1) begin
              e = (exp_q.size() > 0) ? exp_q.pop_front() : last_smp;
              check(word == (32'(e) << (SW - 16)), $sformatf("i%0d_slot_word", g), word,
                    32'(e) << (SW - 16));
            end
            nbits++;
          end
          if (plr && !lr_w[g]) t_lrf = cyc;
          if (pbusy && !busy_w[g]) begin
            check(t_lrf >= 0 && cyc - t_lrf == 2 * CD, $sformatf("i%0d_drain_end", g),
                  cyc - t_lrf, 2 * CD);
            check(nbits > 0 && nbits % (2 * SW) == 0, $sformatf("i%0d_whole_frames", g), nbits, 2 * SW);
            check(exp_q.size() == 0, $sformatf("i%0d_samples_consumed", g), exp_q.size(), 0);
            check({bclk_w[g], lr_w[g], sd_w[g]} == 3'b0, $sformatf("i%0d_idle_outputs", g),
                  {bclk_w[g], lr_w[g], sd_w[g]}, 0);
            nbits = 0; t_rise = -1;
          end
          pb = bclk_w[g]; plr = lr_w[g]; pbusy = busy_w[g];
        end
      end
    end
  end

  task automatic wait_idle(input int g);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy_w[g] && n < 20000);
    check(!busy_w[g], $sformatf("i%0d_idle_timeout", g), busy_w[g], 0);
  endtask

  // Enable held for on_cyc cycles, then held low until the transmitter is idle again.
  task automatic session(input int g, input int on_cyc);
    @(negedge clk);
    #1 en[g] = 1'b1;
    repeat (on_cyc) @(negedge clk);
    #1 en[g] = 1'b0;
    wait_idle(g);
  endtask

  task automatic reset_mid_right();
    int n;
    @(negedge clk);
    #1 en[0] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!lr_w[0] && n < 5000);
    check(lr_w[0], "i0_reach_right_slot", lr_w[0], 1);
    repeat (20) @(negedge clk);
    #1 rstn[0] = 1'b0;
    @(negedge clk);
    #1 rstn[0] = 1'b1;
    repeat ($urandom_range(300, 600)) @(negedge clk);
    #1 en[0] = 1'b0;
    wait_idle(0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      en[i]   = 1'b0;
      rstn[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) rstn[i] = 1'b1;
    fork
      begin
        session(0, 700);
        reset_mid_right();
        for (int i = 0; i < 6; i++) session(0, $urandom_range(1, 700));
      end
      begin
        for (int i = 0; i < 6; i++) session(1, $urandom_range(1, 1600));
      end
      begin
        for (int i = 0; i < 40; i++) session(2, $urandom_range(1, 80));
      end
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded its cycle budget at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
